// File: rtl/sysid_probe_master.sv
// ---------------------------------------------------------------------------
// sysid_probe_master
//
// Reads two words from an Avalon-MM system-ID slave and compares them with
// the expected build ID (word 0) and build timestamp (word 1). The slave is
// polled only on request. Each phase has a bounded wait. A stuck or absent
// slave therefore ends the probe with the timeout flag set instead of
// hanging.
//
// Ports
//   clock              single rising-edge clock
//   reset_n            asynchronous active-low reset
//   start              probe request, level-sampled while idle
//   avm_address        word address (0 = ID, 1 = timestamp)
//   avm_read           read request, held until waitrequest is low
//   avm_waitrequest    slave stall
//   avm_readdata       read data, qualified by avm_readdatavalid
//   avm_readdatavalid  read data qualifier
//   busy               high while a probe is in progress
//   done               one-clock completion pulse
//   id_ok, ts_ok       captured word matched its expected value
//   timeout            a phase exceeded TIMEOUT_CYCLES
//   id_value, ts_value captured words, held until the next probe starts
// ---------------------------------------------------------------------------
module sysid_probe_master #(
   parameter logic [31:0] EXPECTED_ID    = 32'd2899645186,
   parameter logic [31:0] EXPECTED_TS    = 32'd1448799059,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WT_ID,
      RD_TS,
      WT_TS,
      FIN
   } state_e;

   localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic [15:0] cnt_inc;
   logic        limit_hit;

   // The counter saturates so it cannot wrap back below the limit. The
   // limit test is ">=" rather than "==". The wait phase inherits the count
   // of its read phase. If the read was accepted in the same clock the limit
   // was reached, the wait phase starts already at or past the limit. It
   // must still time out if no data ever arrives.
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
   assign limit_hit = ({1'b0, cnt_q} + 17'd1) >= LIMIT;

   // NOTE: every comb output gets a default before the case statement, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      id_ok_d     = id_ok_q;
      ts_ok_d     = ts_ok_q;
      timeout_d   = timeout_q;
      id_value_d  = id_value_q;
      ts_value_d  = ts_value_q;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      busy        = (state_q != IDLE);
      done        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RD_ID;
               cnt_d      = '0;
               id_ok_d    = 1'b0;
               ts_ok_d    = 1'b0;
               timeout_d  = 1'b0;
               id_value_d = '0;
               ts_value_d = '0;
            end
         end
         RD_ID: begin
            avm_read = 1'b1;
            cnt_d    = cnt_inc;
            // Acceptance wins over the limit when both occur in the same clock.
            if (!avm_waitrequest) begin
               state_d = WT_ID;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         WT_ID: begin
            cnt_d = cnt_inc;
            if (avm_readdatavalid) begin
               id_value_d = avm_readdata;
               id_ok_d    = (avm_readdata == EXPECTED_ID);
               cnt_d      = '0;
               state_d    = RD_TS;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         RD_TS: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            cnt_d       = cnt_inc;
            if (!avm_waitrequest) begin
               state_d = WT_TS;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         WT_TS: begin
            cnt_d = cnt_inc;
            if (avm_readdatavalid) begin
               ts_value_d = avm_readdata;
               ts_ok_d    = (avm_readdata == EXPECTED_TS);
               state_d    = FIN;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its pre-edge value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
      end
   end

   assign id_ok    = id_ok_q;
   assign ts_ok    = ts_ok_q;
   assign timeout  = timeout_q;
   assign id_value = id_value_q;
   assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// ---------------------------------------------------------------------------
// tb_sysid_probe_master
//
// Directed bench for sysid_probe_master built with TIMEOUT_CYCLES = 8.
// A behavioural Avalon-MM slave answers the reads. It supports configurable
// wait states, a stuck waitrequest per address, and a one-cycle read latency.
// Each started probe pushes its expected completion into a queue. The
// monitor pops one entry on every done pulse and compares the completion
// clock, the flags, the captured words and the number of avm_read clocks.
// ---------------------------------------------------------------------------
module tb_sysid_probe_master;

   localparam logic [31:0] ID_W = 32'd2899645186;
   localparam logic [31:0] TS_W = 32'd1448799059;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   sysid_probe_master #(
      .EXPECTED_ID    (ID_W),
      .EXPECTED_TS    (TS_W),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .timeout           (timeout),
      .id_value          (id_value),
      .ts_value          (ts_value)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int          done_cyc;
      logic        id_ok;
      logic        ts_ok;
      logic        to;
      logic [31:0] iv;
      logic [31:0] tv;
      int          rdc;
   } exp_t;

   exp_t exp_q[$];

   task automatic exp_push(input int t0, input int clocks, input logic iok, input logic tok,
                           input logic to, input logic [31:0] iv, input logic [31:0] tv,
                           input int rdc);
      exp_t e;
      e.done_cyc = t0 + clocks - 1;
      e.id_ok    = iok;
      e.ts_ok    = tok;
      e.to       = to;
      e.iv       = iv;
      e.tv       = tv;
      e.rdc      = rdc;
      exp_q.push_back(e);
   endtask

   // ---------------- slave model ----------------
   int          wait_n   = 0;
   logic        stuck0   = 1'b0;
   logic        stuck1   = 1'b0;
   logic [31:0] d0       = ID_W;
   logic [31:0] d1       = TS_W;
   logic        pend     = 1'b0;
   logic        pend_adr = 1'b0;
   int          wr_cnt   = 0;

   initial begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
   end

   always @(negedge clock) begin
      if (!reset_n) begin
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = '0;
         pend              = 1'b0;
         wr_cnt            = 0;
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = '0;
         if (pend) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_adr ? d1 : d0;
            pend              = 1'b0;
         end
         avm_waitrequest = 1'b0;
         if (avm_read) begin
            if ((avm_address ? stuck1 : stuck0) || wr_cnt < wait_n) begin
               avm_waitrequest = 1'b1;
               wr_cnt++;
            end else begin
               pend     = 1'b1;
               pend_adr = avm_address;
               wr_cnt   = 0;
            end
         end else begin
            wr_cnt = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   int   rd_cnt    = 0;
   int   proto_bad = 0;
   logic prev_read = 1'b0;
   logic prev_adr  = 1'b0;

   always @(posedge clock) begin
      #1;
      if (!reset_n) begin
         rd_cnt    = 0;
         proto_bad = 0;
         prev_read = 1'b0;
         prev_adr  = 1'b0;
      end else begin
         // A stalled read must keep request and address stable. A stuck
         // slave is the exception, because there the master drops the read
         // on timeout.
         if (prev_read && avm_waitrequest && !(prev_adr ? stuck1 : stuck0))
            if (!avm_read || avm_address != prev_adr) proto_bad++;
         if (!avm_read && avm_address) proto_bad++;
         if (avm_read) rd_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", done, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("busy_at_done", busy, 1'b1);
               check("id_ok", id_ok, e.id_ok);
               check("ts_ok", ts_ok, e.ts_ok);
               check("timeout", timeout, e.to);
               check("id_value", id_value, e.iv);
               check("ts_value", ts_value, e.tv);
               check("read_clocks", rd_cnt, e.rdc);
               check("protocol", proto_bad, 0);
            end
            rd_cnt    = 0;
            proto_bad = 0;
         end
         prev_read = avm_read;
         prev_adr  = avm_address;
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_pulse(output int t0);
      @(negedge clock);
      start = 1'b1;
      t0    = cyc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      check({"drain_", name}, exp_q.size(), 0);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      int t0;
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_read", avm_read, 1'b0);
      check("rst_addr", avm_address, 1'b0);
      check("rst_flags", {id_ok, ts_ok, timeout}, 3'b000);
      check("rst_values", {id_value, ts_value}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Zero-wait slave: minimum latency of six clocks.
      start_pulse(t0);
      exp_push(t0, 6, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 2);
      drain("zero_wait");

      // Three wait states on each read, plus a start pulse while busy.
      wait_n = 3;
      start_pulse(t0);
      exp_push(t0, 12, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 8);
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      drain("wait3");

      // Timestamp word reads back as zero.
      wait_n = 0;
      d1     = 32'h0;
      start_pulse(t0);
      exp_push(t0, 6, 1'b1, 1'b0, 1'b0, ID_W, 32'h0, 2);
      drain("ts_zero");

      // Wrong ID word.
      d1 = TS_W;
      d0 = 32'h1234_5678;
      start_pulse(t0);
      exp_push(t0, 6, 1'b0, 1'b1, 1'b0, 32'h1234_5678, TS_W, 2);
      drain("id_bad");
      d0 = ID_W;

      // Waitrequest stuck on the ID read: the read drops after eight clocks.
      stuck0 = 1'b1;
      start_pulse(t0);
      exp_push(t0, 10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 8);
      drain("stuck_id");
      stuck0 = 1'b0;

      // Waitrequest stuck on the timestamp read: the ID result survives.
      stuck1 = 1'b1;
      start_pulse(t0);
      exp_push(t0, 12, 1'b1, 1'b0, 1'b1, ID_W, 32'h0, 9);
      drain("stuck_ts");
      stuck1 = 1'b0;

      // Acceptance in the same clock the limit is reached: completion wins.
      wait_n = 7;
      start_pulse(t0);
      exp_push(t0, 20, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 16);
      drain("limit_edge");
      wait_n = 0;

      // Reset while in WT_TS: the probe is abandoned and no done appears.
      start_pulse(t0);
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_read", avm_read, 1'b0);
      check("midrst_flags", {id_ok, ts_ok, timeout}, 3'b000);
      check("midrst_values", {id_value, ts_value}, 64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      start_pulse(t0);
      exp_push(t0, 6, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 2);
      drain("after_reset");

      // Start held high: back-to-back probes with one idle clock between.
      @(negedge clock);
      start = 1'b1;
      t0    = cyc;
      exp_push(t0, 6, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 2);
      exp_push(t0 + 6, 6, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 2);
      exp_push(t0 + 12, 6, 1'b1, 1'b1, 1'b0, ID_W, TS_W, 2);
      while (cyc < t0 + 13) @(negedge clock);
      start = 1'b0;
      drain("held_start");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard so the run always ends, even if the stimulus stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
